mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between the instruction fetcher
// (IF, word reads) and the load/store buffer (LS, byte/half/word reads and
// writes). Multi-byte accesses are split into consecutive byte cycles,
// little-endian, with 32-bit wrapping address arithmetic.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; 0 freezes all state
//   has_misbranch       pipeline flush; aborts reads, never writes
//   mem_din/mem_dout    RAM read byte (one cycle after address) / write byte
//   mem_a, mem_wr       RAM byte address and write strobe
//   if_req/if_addr      fetch request, held until if_done
//   if_done/if_data     one-cycle completion pulse with the instruction word
//   ls_req/ls_wr/ls_size/ls_addr/ls_wdata   LS request, held until ls_done
//   ls_done/ls_rdata    one-cycle completion pulse, load data zero-extended
module mem_arbiter #(
  parameter logic [31:0] BOUND = 32'h30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        has_misbranch,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [2:0]  cnt_r;
  logic [2:0]  len_r;
  logic        own_ls_r;
  logic        last_ls_r;
  logic        wr_r;
  logic        io_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] data_r;
  logic [31:0] if_data_r;
  logic [31:0] ls_rdata_r;

  logic        grant_s;
  logic        grant_ls_s;
  logic        last_step_s;
  logic        flush_s;
  logic        io_abort_s;
  logic        issue_s;
  logic [4:0]  cap_idx_s;
  logic [31:0] cap_s;

  // Writes finish on the cycle of their last byte; reads need one more
  // cycle to capture the byte returned for the last address.
  assign last_step_s = wr_r ? (cnt_r == (len_r - 3'd1)) : (cnt_r == len_r);
  // A flush kills anything except an LS write already being committed.
  assign flush_s     = has_misbranch && !(own_ls_r && wr_r);
  // IO reads may have side effects, so stop issuing if LS withdraws.
  assign io_abort_s  = own_ls_r && !wr_r && io_r && !ls_req;

  // Merge the byte returned for address cnt-1 into the assembled word.
  always_comb begin
    cap_idx_s = {cnt_r[1:0] - 2'd1, 3'b000};
    cap_s     = data_r;
    if (cnt_r != 3'd0) begin
      cap_s[cap_idx_s +: 8] = mem_din;
    end else begin
      cap_s = data_r;
    end
  end

  // Next-state and arbitration decision.
  always_comb begin
    state_s    = state_r;
    grant_s    = 1'b0;
    grant_ls_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (rdy && !has_misbranch && (if_req || ls_req)) begin
          grant_s    = 1'b1;
          // On a tie the requester not granted last time wins.
          grant_ls_s = ls_req && (!if_req || !last_ls_r);
          state_s    = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (flush_s || io_abort_s) begin
          state_s = IDLE;
        end else if (rdy && last_step_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (flush_s || rdy) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Memory port and completion pulses; all quiet outside active byte cycles.
  always_comb begin
    issue_s  = (state_r == BUSY) && (cnt_r < len_r) && !rst;
    mem_a    = issue_s ? (addr_r + {29'd0, cnt_r}) : 32'd0;
    mem_wr   = issue_s && wr_r && rdy;
    mem_dout = (issue_s && wr_r) ? wdata_r[{cnt_r[1:0], 3'b000} +: 8] : 8'd0;
    if_done  = (state_r == DONE) && !own_ls_r && rdy && !has_misbranch && !rst;
    ls_done  = (state_r == DONE) && own_ls_r && rdy && !flush_s && !rst;
  end

  assign if_data  = if_data_r;
  assign ls_rdata = ls_rdata_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch, byte counter and read-data assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= 3'd0;
      len_r      <= 3'd0;
      own_ls_r   <= 1'b0;
      last_ls_r  <= 1'b0;
      wr_r       <= 1'b0;
      io_r       <= 1'b0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      data_r     <= 32'd0;
      if_data_r  <= 32'd0;
      ls_rdata_r <= 32'd0;
    end else if (grant_s) begin
      own_ls_r  <= grant_ls_s;
      last_ls_r <= grant_ls_s;
      cnt_r     <= 3'd0;
      data_r    <= 32'd0;
      if (grant_ls_s) begin
        wr_r    <= ls_wr;
        addr_r  <= ls_addr;
        wdata_r <= ls_wdata;
        io_r    <= (ls_addr >= BOUND);
        case (ls_size)
          2'b00:   len_r <= 3'd1;
          2'b01:   len_r <= 3'd2;
          default: len_r <= 3'd4;
        endcase
      end else begin
        wr_r    <= 1'b0;
        addr_r  <= if_addr;
        wdata_r <= 32'd0;
        io_r    <= 1'b0;
        len_r   <= 3'd4;
      end
    end else if ((state_r == BUSY) && (state_s == BUSY) && rdy) begin
      cnt_r <= cnt_r + 3'd1;
      if (!wr_r) begin
        data_r <= cap_s;
      end else begin
        data_r <= data_r;
      end
    end else if ((state_r == BUSY) && (state_s == DONE)) begin
      cnt_r <= 3'd0;
      if (!wr_r && own_ls_r) begin
        ls_rdata_r <= cap_s;
      end else if (!wr_r) begin
        if_data_r <= cap_s;
      end else begin
        ls_rdata_r <= ls_rdata_r;
      end
    end else if (state_s == IDLE) begin
      cnt_r <= 3'd0;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with exact cycle
// timing plus randomized transactions checked against a byte-array model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        has_misbranch;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  int checks;
  int failures;

  logic [7:0] ram [0:1023];
  logic [7:0] exp_mem [0:1023];
  logic       pre_we;
  logic [9:0] pre_a;
  logic [7:0] pre_d;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .has_misbranch(has_misbranch),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 1 KiB aliased window, read data one cycle late, stalls with rdy.
  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (rdy && mem_wr) ram[mem_a[9:0]] <= mem_dout;
    if (rdy) mem_din <= ram[mem_a[9:0]];
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    next_cycle();
    pre_we = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; rdy = 1'b1; has_misbranch = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rdy = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_wr = 1'b1;
    ls_size = 2'd2; ls_addr = 32'h80; ls_wdata = 32'hFFFFFFFF; if_addr = 32'h44;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({mem_a, mem_dout, mem_wr, if_done, ls_done, if_data, ls_rdata} !== 107'd0) begin
      failures++;
      $display("FAIL reset_outputs mem_a=%h dout=%h wr=%b ifd=%b lsd=%b if_data=%h ls_rdata=%h want all 0",
               mem_a, mem_dout, mem_wr, if_done, ls_done, if_data, ls_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_a !== 32'd0 || mem_wr !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset mem_a=%h wr=%b want 0 0", mem_a, mem_wr);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (mem_a !== 32'h44) begin
      failures++;
      $display("FAIL first_grant mem_a=%h want 00000044", mem_a);
    end
  endtask

  task automatic test_fetch;
    poke(10'd0, 8'h13); poke(10'd1, 8'h05); poke(10'd2, 8'h00); poke(10'd3, 8'h00);
    do_reset();
    if_req = 1'b1; if_addr = 32'd0;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        checks++;
        if (mem_a !== 32'(c - 1) || mem_wr !== 1'b0) begin
          failures++;
          $display("FAIL fetch_addr cycle %0d mem_a=%h wr=%b want %h 0", c, mem_a, mem_wr, 32'(c - 1));
        end
      end
      checks++;
      if (if_done !== (c == 6)) begin
        failures++;
        $display("FAIL fetch_done cycle %0d if_done=%b want %b", c, if_done, (c == 6));
      end
      if (c == 6) begin
        checks++;
        if (if_data !== 32'h00000513) begin
          failures++;
          $display("FAIL fetch_data if_data=%h want 00000513", if_data);
        end
      end
      next_cycle();
      if (c == 6) if_req = 1'b0;
    end
  endtask

  task automatic test_store;
    poke(10'h100, 8'h00); poke(10'h101, 8'h00); poke(10'h102, 8'h5A);
    do_reset();
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b01; ls_addr = 32'h100; ls_wdata = 32'hABCD1234;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (c == 1 && {mem_wr, mem_a, mem_dout} !== {1'b1, 32'h100, 8'h34}) begin
        failures++;
        $display("FAIL store_byte0 wr=%b a=%h d=%h want 1 100 34", mem_wr, mem_a, mem_dout);
      end else if (c == 2 && {mem_wr, mem_a, mem_dout} !== {1'b1, 32'h101, 8'h12}) begin
        failures++;
        $display("FAIL store_byte1 wr=%b a=%h d=%h want 1 101 12", mem_wr, mem_a, mem_dout);
      end else if ((c == 0 || c >= 3) && mem_wr !== 1'b0) begin
        failures++;
        $display("FAIL store_quiet cycle %0d wr=%b want 0", c, mem_wr);
      end
      checks++;
      if (ls_done !== (c == 3)) begin
        failures++;
        $display("FAIL store_done cycle %0d ls_done=%b want %b", c, ls_done, (c == 3));
      end
      next_cycle();
      if (c == 3) ls_req = 1'b0;
    end
    checks++;
    if ({ram[10'h100], ram[10'h101], ram[10'h102]} !== 24'h34125A) begin
      failures++;
      $display("FAIL store_ram got %h%h%h want 34125a", ram[10'h100], ram[10'h101], ram[10'h102]);
    end
  endtask

  task automatic test_tie;
    logic got;
    poke(10'h10, 8'h11); poke(10'h11, 8'h22); poke(10'h12, 8'h33); poke(10'h13, 8'h44);
    poke(10'd0, 8'h13); poke(10'd1, 8'h05); poke(10'd2, 8'h00); poke(10'd3, 8'h00);
    do_reset();
    if_req = 1'b1; if_addr = 32'd0;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'h10;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (mem_a !== 32'h10) begin
          failures++;
          $display("FAIL tie_first_ls mem_a=%h want 00000010", mem_a);
        end
      end
      if (c == 6) begin
        checks++;
        if (ls_done !== 1'b1 || ls_rdata !== 32'h44332211 || if_done !== 1'b0) begin
          failures++;
          $display("FAIL tie_ls_done lsd=%b data=%h ifd=%b want 1 44332211 0", ls_done, ls_rdata, if_done);
        end
      end
      if (c == 8) begin
        checks++;
        if (mem_a !== 32'd0) begin
          failures++;
          $display("FAIL tie_then_if mem_a=%h want 00000000", mem_a);
        end
      end
      next_cycle();
    end
    ls_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (if_done) begin
        got = 1'b1;
        checks++;
        if (if_data !== 32'h00000513) begin
          failures++;
          $display("FAIL tie_if_data if_data=%h want 00000513", if_data);
        end
      end
      next_cycle();
    end
    if_req = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL tie_if_timeout if_done=0 want 1");
    end
  endtask

  task automatic test_flush;
    int dones;
    logic [31:0] w;
    do_reset();
    if_req = 1'b1; if_addr = 32'h20; dones = 0;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (if_done) dones++;
      if (c == 4) begin
        checks++;
        if (mem_a !== 32'd0 || mem_wr !== 1'b0) begin
          failures++;
          $display("FAIL flush_idle mem_a=%h wr=%b want 0 0", mem_a, mem_wr);
        end
      end
      next_cycle();
      if (c == 2) has_misbranch = 1'b1;
      if (c == 3) begin has_misbranch = 1'b0; if_req = 1'b0; end
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL flush_no_done if_done pulses=%0d want 0", dones);
    end
    w = $urandom;
    do_reset();
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b10; ls_addr = 32'h200; ls_wdata = w;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        checks++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h200 + 32'(c - 1), w[8*(c-1) +: 8]}) begin
          failures++;
          $display("FAIL flush_write cycle %0d wr=%b a=%h d=%h want 1 %h %h", c, mem_wr, mem_a, mem_dout,
                   32'h200 + 32'(c - 1), w[8*(c-1) +: 8]);
        end
      end
      checks++;
      if (ls_done !== (c == 5)) begin
        failures++;
        $display("FAIL flush_write_done cycle %0d ls_done=%b want %b", c, ls_done, (c == 5));
      end
      next_cycle();
      if (c == 1) has_misbranch = 1'b1;
      if (c == 2) has_misbranch = 1'b0;
      if (c == 5) ls_req = 1'b0;
    end
  endtask

  task automatic test_stall;
    logic [31:0] v;
    v = $urandom;
    for (int i = 0; i < 4; i++) poke(10'(32'h40 + i), v[8*i +: 8]);
    do_reset();
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'h40;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      checks++;
      if (mem_wr !== 1'b0 || ls_done !== (c == 9)) begin
        failures++;
        $display("FAIL stall cycle %0d wr=%b ls_done=%b want 0 %b", c, mem_wr, ls_done, (c == 9));
      end
      if (c == 9) begin
        checks++;
        if (ls_rdata !== v) begin
          failures++;
          $display("FAIL stall_data ls_rdata=%h want %h", ls_rdata, v);
        end
      end
      next_cycle();
      if (c == 1) rdy = 1'b0;
      if (c == 4) rdy = 1'b1;
      if (c == 9) ls_req = 1'b0;
    end
  endtask

  task automatic test_wrap;
    poke(10'h3FF, 8'hAA); poke(10'h000, 8'hBB);
    do_reset();
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b01; ls_addr = 32'hFFFFFFFF;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1 || c == 2) begin
        checks++;
        if (mem_a !== ((c == 1) ? 32'hFFFFFFFF : 32'h0)) begin
          failures++;
          $display("FAIL wrap_addr cycle %0d mem_a=%h want %h", c, mem_a, (c == 1) ? 32'hFFFFFFFF : 32'h0);
        end
      end
      checks++;
      if (ls_done !== (c == 4)) begin
        failures++;
        $display("FAIL wrap_done cycle %0d ls_done=%b want %b", c, ls_done, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if (ls_rdata !== 32'h0000BBAA) begin
          failures++;
          $display("FAIL wrap_data ls_rdata=%h want 0000bbaa", ls_rdata);
        end
      end
      next_cycle();
      if (c == 4) ls_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    poke(10'h40, 8'h5C);
    do_reset();
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b00; ls_addr = 32'h40;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) begin
        checks++;
        if (ls_done !== 1'b1 || ls_rdata !== 32'h5C) begin
          failures++;
          $display("FAIL byte_load lsd=%b data=%h want 1 0000005c", ls_done, ls_rdata);
        end
      end
      next_cycle();
    end
    ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; if_req = 1'b0; dones = 0;
    @(negedge clk);
    checks++;
    if (ls_rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_rdata ls_rdata=%h want 0", ls_rdata);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if_done || ls_done) dones++;
      next_cycle();
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL reset_mid_done pulses=%0d want 0", dones);
    end
  endtask

  task automatic test_random;
    int unsigned n, addr, edges, exp_edges;
    logic is_ls, wr, got;
    logic [1:0]  size;
    logic [31:0] wdata, exp_data, got_data;
    int bad;
    for (int i = 0; i < 1024; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_mem[i] = b;
      poke(10'(i), b);
    end
    do_reset();
    for (int t = 0; t < 40; t++) begin
      is_ls = 1'($urandom_range(0, 1));
      wr    = is_ls & 1'($urandom_range(0, 1));
      size  = is_ls ? 2'($urandom_range(0, 2)) : 2'd2;
      n     = 1 << size;
      addr  = $urandom_range(0, 1019);
      wdata = $urandom;
      exp_data = 32'd0;
      if (!wr) for (int k = 0; k < int'(n); k++) exp_data[8*k +: 8] = exp_mem[10'(addr + k)];
      exp_edges = wr ? n + 1 : n + 2;
      if (is_ls) begin
        ls_req = 1'b1; ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata;
      end else begin
        if_req = 1'b1; if_addr = addr;
      end
      edges = 0; got = 1'b0;
      for (int k = 0; k < 80 && !got; k++) begin
        @(negedge clk);
        if (!rdy) begin
          checks++;
          if (mem_wr !== 1'b0) begin
            failures++;
            $display("FAIL rand_stall_wr txn %0d mem_wr=%b want 0", t, mem_wr);
          end
        end
        if (if_done || ls_done) begin
          got = 1'b1;
          got_data = is_ls ? ls_rdata : if_data;
          checks++;
          if ({if_done, ls_done} !== {~is_ls, is_ls}) begin
            failures++;
            $display("FAIL rand_owner txn %0d ifd=%b lsd=%b want %b %b", t, if_done, ls_done, ~is_ls, is_ls);
          end
          checks++;
          if (edges !== exp_edges) begin
            failures++;
            $display("FAIL rand_latency txn %0d active_edges=%0d want %0d", t, edges, exp_edges);
          end
          if (!wr) begin
            checks++;
            if (got_data !== exp_data) begin
              failures++;
              $display("FAIL rand_data txn %0d addr=%h n=%0d got=%h want %h", t, addr, n, got_data, exp_data);
            end
          end
        end else begin
          @(posedge clk);
          if (rdy) edges++;
          #1;
          rdy = ($urandom_range(0, 3) != 0);
        end
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL rand_timeout txn %0d no done pulse want one", t);
      end
      @(posedge clk); #1;
      if_req = 1'b0; ls_req = 1'b0; rdy = 1'b1;
      if (wr) for (int k = 0; k < int'(n); k++) exp_mem[10'(addr + k)] = wdata[8*k +: 8];
      next_cycle();
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== exp_mem[i]) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rand_ram_final mismatching bytes=%0d want 0", bad);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; rdy = 1'b1; has_misbranch = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
    pre_we = 1'b0; pre_a = 10'd0; pre_d = 8'd0;
    test_reset();
    test_fetch();
    test_store();
    test_tie();
    test_flush();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
